spi_dma_wbiu: RTL and testbench

SPI_DMA_WBIU -- requirements
Module: spi_dma_wbiu

---
 rtl/spi_dma_pkg.sv | 21 ++
 rtl/spi_dma_skid.sv | 46 ++++
 rtl/spi_dma_wbiu.sv | 167 ++++++++++++++++
 tb/tb_spi_dma_wbiu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dma_pkg.sv
// spi_dma_pkg: shared FSM state and beat types for the SPI DMA Avalon bridge.
// HOLD exists only when SPI_DMA_WBIU_WRSP_EN is defined.
package spi_dma_pkg;

    localparam int unsigned BEAT_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        BURST
`ifdef SPI_DMA_WBIU_WRSP_EN
        , HOLD
`endif
    } state_e;

    typedef struct packed {
        logic [BEAT_DW-1:0] dat;
        logic               sob;
        logic               eob;
    } beat_t;

endpackage

// File: rtl/spi_dma_skid.sv
// spi_dma_skid: 2-entry skid buffer; ready is a registered "not full".
// The head entry is presented directly, so it stays put until popped.
module spi_dma_skid #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_val_i,
    input  logic [W-1:0] in_dat_i,
    output logic         in_rdy_o,
    output logic         out_val_o,
    output logic [W-1:0] out_dat_o,
    input  logic         out_pop_i
);

    logic [W-1:0] mem_q [2];
    logic         wp_q, rp_q, rdy_q;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign push      = in_val_i && rdy_q;
    assign pop       = out_pop_i && (cnt_q != 2'd0);
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    assign in_rdy_o  = rdy_q;
    assign out_val_o = (cnt_q != 2'd0);
    assign out_dat_o = mem_q[rp_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b0;
        end else begin
            if (push) wp_q <= ~wp_q;
            if (pop)  rp_q <= ~rp_q;
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= in_dat_i;
    end

endmodule

// File: rtl/spi_dma_wbiu.sv
// spi_dma_wbiu: beat stream to Avalon-MM burst write bridge.
// SPI_DMA_WBIU_WRSP_EN enables write-response tracking and HOLD.
import spi_dma_pkg::*;

module spi_dma_wbiu #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int AL = 2,
    parameter int BL = 4,
    parameter int OW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   biu_adr,
    input  logic [BL:0]     biu_len,
    input  logic            biu_sob,
    input  logic            biu_eob,
    input  logic [DW-1:0]   biu_dat,
    input  logic            biu_val,
    output logic            biu_rdy,
    output logic            rsp_val,
    output logic [AW-1:0]   avm_address,
    output logic [BL:0]     avm_burstcount,
    output logic            avm_write,
    output logic [DW-1:0]   avm_writedata,
    output logic [DW/8-1:0] avm_byteenable,
    input  logic            avm_waitrequest,
    input  logic            avm_writeresponsevalid,
    output logic            err
);

    localparam int          PW   = AW + BL + 1 + $bits(beat_t);
    localparam logic [BL:0] LEN1 = (BL+1)'(1);
    localparam logic [BL:0] LMAX = (BL+1)'(2 ** BL);

    state_e        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d, hd_adr;
    logic [BL:0]   bc_q, bc_d, cnt_q, cnt_d;
    logic [BL:0]   hd_len, len_eff;
    logic          err_q, err_d, rsp_q, done;
    logic          hd_val, out_full, acc, bad_len;
    logic [PW-1:0] in_w, hd_w;
    beat_t         in_beat, hd_beat;

    assign in_beat = '{dat: biu_dat, sob: biu_sob, eob: biu_eob};
    assign in_w    = {biu_adr, biu_len, in_beat};

    spi_dma_skid #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_val_i  (biu_val),
        .in_dat_i  (in_w),
        .in_rdy_o  (biu_rdy),
        .out_val_o (hd_val),
        .out_dat_o (hd_w),
        .out_pop_i (acc)
    );

    assign {hd_adr, hd_len, hd_beat} = hd_w;
    assign bad_len = (hd_len == '0) || (hd_len > LMAX);
    assign len_eff = bad_len ? LEN1 : hd_len;

`ifdef SPI_DMA_WBIU_WRSP_EN
    logic [OW-1:0] out_q, out_d;
    logic          inc, dec;

    assign out_full = (out_q == '1);
    assign inc      = done;
    assign dec      = avm_writeresponsevalid && (out_q != '0);

    always_comb begin
        out_d = out_q;
        unique case ({inc, dec})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end
`else
    logic [OW:0] unused_w;
    assign unused_w = {avm_writeresponsevalid, {OW{1'b0}}};
    assign out_full = 1'b0;
`endif

    // First beat drives address/count straight from the head entry.
    assign avm_write = hd_val && ((state_q == BURST) ||
                                  ((state_q == IDLE) && !out_full));
    assign acc            = avm_write && !avm_waitrequest;
    assign avm_address    = (state_q == IDLE && hd_val) ? hd_adr : adr_q;
    assign avm_burstcount = (state_q == IDLE && hd_val) ? len_eff : bc_q;
    assign avm_writedata  = hd_beat.dat;
    assign avm_byteenable = {(2 ** AL){1'b1}};
    assign rsp_val        = rsp_q;
    assign err            = err_q;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        bc_d    = bc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    adr_d = hd_adr;
                    bc_d  = len_eff;
                    cnt_d = len_eff - LEN1;
                    if (bad_len || !hd_beat.sob ||
                        (hd_beat.eob != (len_eff == LEN1)))
                        err_d = 1'b1;
                    if (len_eff == LEN1) done = 1'b1;
                    else                 state_d = BURST;
                end
`ifdef SPI_DMA_WBIU_WRSP_EN
                else if (out_full) state_d = HOLD;
`endif
            end
            BURST: begin
                if (acc) begin
                    cnt_d = cnt_q - LEN1;
                    if (hd_beat.sob || (hd_beat.eob != (cnt_q == LEN1)))
                        err_d = 1'b1;
                    if (cnt_q == LEN1) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`ifdef SPI_DMA_WBIU_WRSP_EN
            HOLD: if (!out_full) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
`ifdef SPI_DMA_WBIU_WRSP_EN
        if (avm_writeresponsevalid && (out_q == '0)) err_d = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            bc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rsp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            bc_q    <= bc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef SPI_DMA_WBIU_WRSP_EN
            rsp_q   <= avm_writeresponsevalid;
`else
            rsp_q   <= done;
`endif
        end
    end

endmodule

// File: tb/tb_spi_dma_wbiu.sv
// tb_spi_dma_wbiu: directed self-checking bench for spi_dma_wbiu.
// Default build checks the no-response mode; SPI_DMA_WBIU_WRSP_EN checks HOLD.
module tb_spi_dma_wbiu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] biu_adr, biu_dat;
    logic [4:0]  biu_len;
    logic        biu_sob, biu_eob, biu_val, biu_rdy;
    logic        rsp_val, avm_write, err;
    logic [31:0] avm_address, avm_writedata;
    logic [4:0]  avm_burstcount;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest, avm_writeresponsevalid;

    spi_dma_wbiu dut (
        .clk                    (clk),
        .rst                    (rst),
        .biu_adr                (biu_adr),
        .biu_len                (biu_len),
        .biu_sob                (biu_sob),
        .biu_eob                (biu_eob),
        .biu_dat                (biu_dat),
        .biu_val                (biu_val),
        .biu_rdy                (biu_rdy),
        .rsp_val                (rsp_val),
        .avm_address            (avm_address),
        .avm_burstcount         (avm_burstcount),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_byteenable         (avm_byteenable),
        .avm_waitrequest        (avm_waitrequest),
        .avm_writeresponsevalid (avm_writeresponsevalid),
        .err                    (err)
    );

    always #5 clk = ~clk;

    int          n_run = 0, n_fail = 0;
    int          cyc = 0;
    logic [31:0] q_adr[$], q_dat[$];
    logic [4:0]  q_bc[$];
    int          q_cyc[$];
    int          rsp_n, stab_bad, rdy_low_n;
    logic        hold_v = 1'b0;
    logic [31:0] h_adr, h_dat;
    logic [4:0]  h_bc;

    always @(posedge clk) cyc <= cyc + 1;

    // Avalon-side observer: records accepted beats, pulses and stalls.
    always @(negedge clk) begin
        if (hold_v && (avm_write !== 1'b1 || avm_address !== h_adr ||
                       avm_burstcount !== h_bc || avm_writedata !== h_dat))
            stab_bad++;
        hold_v = (avm_write === 1'b1 && avm_waitrequest === 1'b1);
        h_adr  = avm_address;
        h_bc   = avm_burstcount;
        h_dat  = avm_writedata;
        if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
            q_adr.push_back(avm_address);
            q_bc.push_back(avm_burstcount);
            q_dat.push_back(avm_writedata);
            q_cyc.push_back(cyc);
        end
        if (rsp_val === 1'b1) rsp_n++;
        if (biu_rdy === 1'b0 && rst === 1'b0) rdy_low_n++;
    end

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i,
                            input logic [31:0] adr, input logic [4:0] bc,
                            input logic [31:0] dat);
        if (i < q_dat.size())
            chk(tag, {q_adr[i], 27'd0, q_bc[i], q_dat[i]},
                {adr, 27'd0, bc, dat});
        else
            chk({tag, "_missing"}, q_dat.size(), i + 1);
    endtask

    task automatic clr();
        q_adr.delete();
        q_bc.delete();
        q_dat.delete();
        q_cyc.delete();
        rsp_n     = 0;
        stab_bad  = 0;
        rdy_low_n = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] adr, input logic [4:0] len,
                             input logic sob, input logic eob,
                             input logic [31:0] dat);
        bit ok = 1'b0;
        biu_adr = adr;
        biu_len = len;
        biu_sob = sob;
        biu_eob = eob;
        biu_dat = dat;
        biu_val = 1'b1;
        for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = (biu_rdy === 1'b1);
            @(posedge clk);
            #1;
        end
        biu_val = 1'b0;
        biu_sob = 1'b0;
        biu_eob = 1'b0;
        if (!ok) chk("beat_accept_timeout", ok, 1'b1);
    endtask

    // Non-first beats carry junk adr/len: only the sob beat may be sampled.
    task automatic send_burst(input logic [31:0] adr, input logic [4:0] len,
                              input int n, input int eob_at,
                              input logic [31:0] d0);
        for (int i = 0; i < n; i++)
            send_beat(i == 0 ? adr : 32'hDEAD_BEEF, i == 0 ? len : 5'd0,
                      i == 0, i == eob_at, d0 + i);
    endtask

    initial begin
        rst = 1'b1;
        biu_adr = '0; biu_dat = '0; biu_len = '0;
        biu_sob = 1'b0; biu_eob = 1'b0; biu_val = 1'b0;
        avm_waitrequest = 1'b0;
        avm_writeresponsevalid = 1'b0;
        clr();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", biu_rdy, 1'b0);
        chk("rst_write", avm_write, 1'b0);
        chk("rst_rsp", rsp_val, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_adr", avm_address, 32'h0);
        chk("rst_bc", avm_burstcount, 5'd0);
        chk("rst_be", avm_byteenable, 4'hF);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_rdy", biu_rdy, 1'b1);
        idle(1);

`ifndef SPI_DMA_WBIU_WRSP_EN
        // len 4, no stalls
        clr();
        send_burst(32'h1000, 5'd4, 4, 3, 32'hA000_0000);
        idle(6);
        chk("s1_beats", q_dat.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_beat("s1_beat", i, 32'h1000, 5'd4, 32'hA000_0000 + i);
        if (q_cyc.size() == 4) chk("s1_consec", q_cyc[3] - q_cyc[0], 3);
        chk("s1_rsp", rsp_n, 1);
        chk("s1_err", err, 1'b0);

        // waitrequest for 3 cycles while beat 2 is presented
        clr();
        fork
            send_burst(32'h1000, 5'd4, 4, 3, 32'hB000_0000);
            begin
                repeat (2) @(posedge clk);
                #1 avm_waitrequest = 1'b1;
                repeat (3) @(posedge clk);
                #1 avm_waitrequest = 1'b0;
            end
        join
        idle(6);
        chk("s2_beats", q_dat.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_beat("s2_beat", i, 32'h1000, 5'd4, 32'hB000_0000 + i);
        if (q_cyc.size() == 4) chk("s2_stall", q_cyc[1] - q_cyc[0], 4);
        chk("s2_stable", stab_bad, 0);
        chk("s2_rdy_fell", rdy_low_n > 0, 1'b1);
        chk("s2_rsp", rsp_n, 1);

        // back-to-back bursts
        clr();
        send_beat(32'h2000, 5'd2, 1'b1, 1'b0, 32'hC000_0000);
        send_beat(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 32'hC000_0001);
        send_beat(32'h3000, 5'd1, 1'b1, 1'b1, 32'hC000_0002);
        idle(6);
        chk("s3_beats", q_dat.size(), 3);
        chk_beat("s3_b0", 0, 32'h2000, 5'd2, 32'hC000_0000);
        chk_beat("s3_b1", 1, 32'h2000, 5'd2, 32'hC000_0001);
        chk_beat("s3_b2", 2, 32'h3000, 5'd1, 32'hC000_0002);
        if (q_cyc.size() == 3) chk("s3_consec", q_cyc[2] - q_cyc[0], 2);
        chk("s3_rsp", rsp_n, 2);
        chk("s3_err", err, 1'b0);

        // eob too early: framing follows burstcount
        clr();
        send_burst(32'h1800, 5'd4, 4, 1, 32'hD000_0000);
        idle(6);
        chk("s4_beats", q_dat.size(), 4);
        for (int i = 0; i < 4; i++)
            chk_beat("s4_beat", i, 32'h1800, 5'd4, 32'hD000_0000 + i);
        chk("s4_err", err, 1'b1);
        chk("s4_rsp", rsp_n, 1);

        // reset on beat 3 of a len 8 burst
        clr();
        send_burst(32'h6000, 5'd8, 3, 99, 32'hE000_0000);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("s5_write", avm_write, 1'b0);
        chk("s5_rdy", biu_rdy, 1'b0);
        chk("s5_rsp_val", rsp_val, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);
        chk("s5_err_clr", err, 1'b0);
        chk("s5_rdy_back", biu_rdy, 1'b1);
        idle(5);
        chk("s5_no_rsp", rsp_n, 0);

        clr();
        send_burst(32'h4000, 5'd2, 2, 1, 32'hF000_0000);
        idle(6);
        chk("s5_beats", q_dat.size(), 2);
        chk_beat("s5_b0", 0, 32'h4000, 5'd2, 32'hF000_0000);
        chk_beat("s5_b1", 1, 32'h4000, 5'd2, 32'hF000_0001);
        chk("s5_rsp", rsp_n, 1);
        chk("s5_err", err, 1'b0);

        // illegal lengths become single-beat bursts
        clr();
        send_beat(32'h5000, 5'd0, 1'b1, 1'b1, 32'h1234_0000);
        send_beat(32'h5100, 5'd17, 1'b1, 1'b1, 32'h1234_0001);
        idle(6);
        chk("s6_beats", q_dat.size(), 2);
        chk_beat("s6_b0", 0, 32'h5000, 5'd1, 32'h1234_0000);
        chk_beat("s6_b1", 1, 32'h5100, 5'd1, 32'h1234_0001);
        chk("s6_rsp", rsp_n, 2);
        chk("s6_err", err, 1'b1);
`else
        // fourth burst must wait for the first response
        clr();
        for (int b = 0; b < 4; b++)
            send_beat(32'h7000 + 32'(b) * 32'h100, 5'd1, 1'b1, 1'b1,
                      32'h9000_0000 + 32'(b));
        idle(8);
        chk("h_held", q_dat.size(), 3);
        chk("h_rsp0", rsp_n, 0);
        avm_writeresponsevalid = 1'b1;
        idle(1);
        avm_writeresponsevalid = 1'b0;
        idle(6);
        chk("h_beats", q_dat.size(), 4);
        chk_beat("h_b3", 3, 32'h7300, 5'd1, 32'h9000_0003);
        chk("h_rsp1", rsp_n, 1);
        chk("h_err", err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
